// File: rtl/activation_pingpong_buffer_pkg.sv
// Shared types and helpers for the PIM activation ping-pong buffer.
package pim_act_pkg;

    localparam int ACT_DATA_W    = 32;
    localparam int ACT_NUM_WORDS = 9;

    typedef logic bank_idx_t;

    // Word 0 sits in the MSBs of the window vector.
    function automatic int word_lsb(input int idx, input int num_words, input int data_w);
        return (num_words - 1 - idx) * data_w;
    endfunction

endpackage

// File: rtl/activation_pingpong_buffer_act_bank.sv
// One activation bank: window storage, per-slot written mask and completeness flag.
module act_bank
    import pim_act_pkg::*;
#(
    parameter int DATA_W    = ACT_DATA_W,
    parameter int NUM_WORDS = ACT_NUM_WORDS,
    parameter int IDX_W     = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_wr_en,
    input  logic [IDX_W-1:0]            i_wr_idx,
    input  logic [DATA_W-1:0]           i_wr_data,
    input  logic                        i_clr,
    input  logic                        i_clr_mask,
    output logic [NUM_WORDS*DATA_W-1:0] o_data,
    output logic                        o_complete
);

    logic [NUM_WORDS*DATA_W-1:0] data_q, data_d;
    logic [NUM_WORDS-1:0]        mask_q, mask_d;
    logic [NUM_WORDS-1:0]        wr_hit;

    always_comb begin
        data_d = data_q;
        wr_hit = '0;
        for (int w = 0; w < NUM_WORDS; w++) begin
            if (i_wr_en && i_wr_idx == IDX_W'(w)) begin
                wr_hit[w] = 1'b1;
                data_d[word_lsb(w, NUM_WORDS, DATA_W) +: DATA_W] = i_wr_data;
            end
        end
        // Commit only clears the mask; the data stays until the window is popped.
        mask_d = i_clr_mask ? '0 : (mask_q | wr_hit);
        if (i_clr) begin
            data_d = '0;
            mask_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            data_q <= '0;
            mask_q <= '0;
        end else begin
            data_q <= data_d;
            mask_q <= mask_d;
        end
    end

    assign o_data     = data_q;
    assign o_complete = &(mask_q | wr_hit);

endmodule

// File: rtl/activation_pingpong_buffer.sv
// Double-buffered activation window assembler between the PIM bus front end and array latch.
// Build option: ACT_BUF_ZERO_FILL_EN accepts incomplete commits (unwritten slots read 0).
module activation_pingpong_buffer
    import pim_act_pkg::*;
#(
    parameter int DATA_W    = ACT_DATA_W,
    parameter int NUM_WORDS = ACT_NUM_WORDS,
    parameter int IDX_W     = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_in_valid,
    input  logic [IDX_W-1:0]            i_in_idx,
    input  logic [DATA_W-1:0]           i_in_data,
    output logic                        o_in_ready,
    input  logic                        i_commit,
    input  logic                        i_flush,
    output logic                        o_out_valid,
    input  logic                        i_out_ready,
    output logic [NUM_WORDS*DATA_W-1:0] o_out_data,
    output logic [1:0]                  o_level,
    output logic                        o_err
);

    logic [1:0]                        full_q, full_d;
    bank_idx_t                         wr_bank_q, wr_bank_d;
    bank_idx_t                         rd_bank_q, rd_bank_d;
    logic                              err_q, err_d;

    logic [1:0][NUM_WORDS*DATA_W-1:0]  bank_data;
    logic [1:0]                        bank_complete;
    logic [1:0]                        bank_wr_en, bank_clr, bank_clr_mask;

    logic in_ready, wr_fire, idx_ok, commit_fire, flush_fire, commit_ok, pop;

    always_comb begin
        in_ready    = !full_q[wr_bank_q];
        wr_fire     = i_in_valid && in_ready;
        idx_ok      = 32'(i_in_idx) < NUM_WORDS;
        commit_fire = i_commit && in_ready;
        flush_fire  = i_flush && in_ready;
        pop         = full_q[rd_bank_q] && i_out_ready;
`ifdef ACT_BUF_ZERO_FILL_EN
        commit_ok   = commit_fire && !flush_fire;
`else
        commit_ok   = commit_fire && !flush_fire && bank_complete[wr_bank_q];
`endif

        // Pop and commit always hit different banks, so both updates can apply.
        full_d = full_q;
        if (pop)       full_d[rd_bank_q] = 1'b0;
        if (commit_ok) full_d[wr_bank_q] = 1'b1;
        wr_bank_d = commit_ok ? ~wr_bank_q : wr_bank_q;
        rd_bank_d = pop ? ~rd_bank_q : rd_bank_q;

        err_d = err_q;
        if (wr_fire && !flush_fire && !idx_ok) err_d = 1'b1;
        if (i_commit && !in_ready)             err_d = 1'b1;
`ifndef ACT_BUF_ZERO_FILL_EN
        if (commit_fire && !flush_fire && !bank_complete[wr_bank_q]) err_d = 1'b1;
`endif

        for (int b = 0; b < 2; b++) begin
            bank_wr_en[b]    = wr_fire && idx_ok && !flush_fire && (wr_bank_q == bank_idx_t'(b));
            bank_clr[b]      = (flush_fire && (wr_bank_q == bank_idx_t'(b)))
                            || (pop && (rd_bank_q == bank_idx_t'(b)));
            bank_clr_mask[b] = commit_ok && (wr_bank_q == bank_idx_t'(b));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            full_q    <= '0;
            wr_bank_q <= '0;
            rd_bank_q <= '0;
            err_q     <= 1'b0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            err_q     <= err_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        act_bank #(
            .DATA_W    (DATA_W),
            .NUM_WORDS (NUM_WORDS),
            .IDX_W     (IDX_W)
        ) u_bank (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .i_wr_en    (bank_wr_en[b]),
            .i_wr_idx   (i_in_idx),
            .i_wr_data  (i_in_data),
            .i_clr      (bank_clr[b]),
            .i_clr_mask (bank_clr_mask[b]),
            .o_data     (bank_data[b]),
            .o_complete (bank_complete[b])
        );
    end

    assign o_in_ready  = in_ready;
    assign o_out_valid = full_q[rd_bank_q];
    assign o_out_data  = full_q[rd_bank_q] ? bank_data[rd_bank_q] : '0;
    assign o_level     = {1'b0, full_q[0]} + {1'b0, full_q[1]};
    assign o_err       = err_q;

endmodule

// File: tb/tb_activation_pingpong_buffer.sv
// Scoreboard bench for activation_pingpong_buffer: committed windows are queued and compared on pop.
module tb_activation_pingpong_buffer;

    localparam int DW = 32;
    localparam int NW = 9;
    localparam int W  = DW * NW;
`ifdef ACT_BUF_ZERO_FILL_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_in_valid = 1'b0;
    logic [7:0]    i_in_idx = '0;
    logic [DW-1:0] i_in_data = '0;
    logic          o_in_ready;
    logic          i_commit = 1'b0;
    logic          i_flush = 1'b0;
    logic          o_out_valid;
    logic          i_out_ready = 1'b0;
    logic [W-1:0]  o_out_data;
    logic [1:0]    o_level;
    logic          o_err;

    activation_pingpong_buffer dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_in_valid  (i_in_valid),
        .i_in_idx    (i_in_idx),
        .i_in_data   (i_in_data),
        .o_in_ready  (o_in_ready),
        .i_commit    (i_commit),
        .i_flush     (i_flush),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_data  (o_out_data),
        .o_level     (o_level),
        .o_err       (o_err)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model of the write side and the queue of committed windows.
    logic [W-1:0]  fill_win = '0;
    logic [NW-1:0] fill_mask = '0;
    logic          m_err = 1'b0;
    logic [W-1:0]  exp_q[$];

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_out(input string tag);
        logic [W-1:0] front;
        front = (exp_q.size() > 0) ? exp_q[0] : '0;
        chk({tag, "_valid"}, W'(o_out_valid), W'(exp_q.size() > 0));
        chk({tag, "_data"},  o_out_data, front);
        chk({tag, "_level"}, W'(o_level), W'(exp_q.size()));
        chk({tag, "_ready"}, W'(o_in_ready), W'(exp_q.size() < 2));
        chk({tag, "_err"},   W'(o_err), W'(m_err));
    endtask

    task automatic wr(input int idx, input logic [DW-1:0] d);
        i_in_idx   = idx[7:0];
        i_in_data  = d;
        i_in_valid = 1'b1;
        tick();
        i_in_valid = 1'b0;
        if (exp_q.size() < 2) begin
            if (idx < NW) begin
                fill_win[(NW-idx)*DW-1 -: DW] = d;
                fill_mask[idx] = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic commit_model(input bit pre_ready);
        if (!pre_ready) m_err = 1'b1;
        else if ((&fill_mask) || ZF) begin
            exp_q.push_back(fill_win);
            fill_win  = '0;
            fill_mask = '0;
        end else m_err = 1'b1;
    endtask

    task automatic commit(input string tag);
        bit r;
        r = exp_q.size() < 2;
        i_commit = 1'b1;
        tick();
        i_commit = 1'b0;
        commit_model(r);
        check_out(tag);
    endtask

    task automatic pop(input string tag);
        i_out_ready = 1'b1;
        tick();
        i_out_ready = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        check_out(tag);
    endtask

    task automatic pop_commit(input string tag);
        bit r;
        r = exp_q.size() < 2;
        i_out_ready = 1'b1;
        i_commit    = 1'b1;
        tick();
        i_out_ready = 1'b0;
        i_commit    = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        commit_model(r);
        check_out(tag);
    endtask

    task automatic flush(input string tag);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        if (exp_q.size() < 2) begin
            fill_win  = '0;
            fill_mask = '0;
        end
        check_out(tag);
    endtask

    task automatic do_reset(input string tag);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        exp_q.delete();
        fill_win  = '0;
        fill_mask = '0;
        m_err     = 1'b0;
        check_out(tag);
    endtask

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) wr(i, $urandom());
    endtask

    initial begin
        tick();
        do_reset("reset");

        // Known-pattern window.
        for (int i = 0; i < NW; i++) wr(i, 32'h11111111 * (i + 1));
        check_out("prefill");
        commit("win1");
        chk("win1_w0", W'(o_out_data[287:256]), W'(32'h11111111));
        chk("win1_w8", W'(o_out_data[31:0]),    W'(32'h99999999));

        // Second window fills the other bank; both full blocks writes and commits.
        fill_rand(NW);
        commit("win2");
        wr(0, 32'hdeadbeef);
        check_out("full_wr");
        commit("full_commit");
        pop("pop1");
        pop("pop2");

        // Stall, then pop and commit together.
        fill_rand(NW);
        commit("win3");
        repeat (5) begin
            tick();
            check_out("stall");
        end
        for (int i = NW - 1; i >= 0; i--) wr(i, $urandom());
        pop_commit("popcommit");
        pop("pop3");

        // Rewrite of a slot overwrites it.
        fill_rand(NW);
        wr(4, 32'hcafef00d);
        commit("rewrite");
        pop("pop4");

        // Incomplete commit.
        do_reset("reset2");
        for (int i = 0; i < NW - 1; i++) wr(i, $urandom());
        commit("partial");
        wr(NW - 1, 32'h0badf00d);
        commit("partial_done");
        while (exp_q.size() > 0) pop("drain1");

        // Out-of-range index, then flush discards partial data and mask.
        do_reset("reset3");
        wr(9, 32'h12345678);
        check_out("bad_idx");
        wr(8, 32'h5a5a5a5a);
        for (int i = 0; i < 4; i++) wr(i, 32'ha0a0a0a0 + i);
        flush("flush");
        for (int i = 0; i < NW - 1; i++) wr(i, 32'h0c0c0c00 + i);
        commit("post_flush_partial");
        wr(NW - 1, 32'h0c0c0c08);
        commit("post_flush_full");
        while (exp_q.size() > 0) pop("drain2");

        // Reset while a window is waiting.
        fill_rand(NW);
        commit("win_pre_rst");
        do_reset("reset_mid");
        tick();
        check_out("after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
